i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h52: 7-bit address this target answers to.
REQ-002 clk  input  1  system clock; all logic on rising edge; clk period SHALL be <= 1/8 of SCL period.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 scl_in  input  1  bus SCL level.
REQ-005 sda_in  input  1  bus SDA level.
REQ-006 sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-007 tx_data  input  8  byte returned on master read; sampled when tx_load pulses.
REQ-008 tx_load  output  1  one-clk pulse: tx_data captured into shifter.
REQ-009 rx_data  output  8  last byte written by master.
REQ-010 rx_valid  output  1  one-clk pulse: rx_data updated.
REQ-011 ack_en  input  1  1 = ACK written bytes, 0 = NACK them (address ACK unaffected).
REQ-012 busy  output  1  high from addressed START until STOP or release.
REQ-013 state  output  3  current FSM state, debug.

Function
REQ-014 scl_in, sda_in SHALL pass through 2-flop synchronizers; edges detected on synchronized values; all responses SHALL occur exactly 3 clk after the bus edge.
REQ-015 START = SDA falls while SCL high; STOP = SDA rises while SCL high; both SHALL be detected in every state and take priority over data handling.
REQ-016 States/encoding: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6.
REQ-017 START (including repeated START) -> ADDR, bit counter cleared, sda_oe=0.
REQ-018 STOP -> IDLE, sda_oe=0, busy=0; any partial byte discarded, no rx_valid.
REQ-019 Data SHALL be sampled on SCL rising edge, MSB first; sda_oe SHALL change only on SCL falling edge.
REQ-020 ADDR: shift 8 bits; after 8th rising edge compare bits[7:1] to TARGET_ADDR; match -> ADDR_ACK, busy=1; mismatch -> IDLE, sda_oe stays 0 until next START.
REQ-021 ADDR_ACK: on next SCL fall assert sda_oe; on following fall release. R/W=0 -> RX. R/W=1 -> TX: tx_load pulses and bit7 driven on that same fall.
REQ-022 RX: after 8th rising edge rx_data updated, rx_valid pulses 1 clk, -> RX_ACK; sda_oe=ack_en sampled at next SCL fall, held one SCL period, then released; -> RX.
REQ-023 TX: sda_oe = ~shifter MSB on each SCL fall; after 8th bit's fall sda_oe=0 and -> TX_ACK.
REQ-024 TX_ACK: sample SDA on SCL rise; 0 (ACK) -> at next fall tx_load pulses, bit7 driven, -> TX; 1 (NACK) -> IDLE, sda_oe=0, busy stays 1 until STOP.
REQ-025 Bit counter 3 bits, wraps 7->0 at byte boundary; multi-byte transfers unlimited.
REQ-026 START during RX_ACK/TX while sda_oe=1 SHALL release sda_oe in the same clk as detection.
REQ-027 SCL/SDA edges in the same synchronized sample: SCL edge processed, SDA change not treated as START/STOP.

Reset
REQ-028 rst SHALL force IDLE, sda_oe=0, tx_load=0, rx_valid=0, busy=0, rx_data=8'h00, counter=0, synchronizers=1.
REQ-029 rst mid-transfer SHALL release SDA within 1 clk; target ignores bus until next START.
REQ-030 First START after rst release SHALL be honoured if synchronizers have seen SCL=SDA=1 for 2 clk.

Verification
REQ-031 Write 0xA4 (addr 0x52,W), data 0x3C, STOP, ack_en=1 -> address ACK, data ACK, rx_data=0x3C, one rx_valid pulse, busy 0 after STOP.
REQ-032 Address 0xA6 (0x53) -> no ACK (SDA high at 9th clock), state returns 0, no tx_load/rx_valid.
REQ-033 Read 0xA5, tx_data 0x96 then 0x0F, master ACK then NACK -> bus bits 10010110, 00001111; two tx_load pulses; sda_oe=0 after NACK.
REQ-034 Write with ack_en=0 -> address ACKed, data byte NACKed, rx_valid still pulses.
REQ-035 Repeated START after write byte, then read 0xA5 -> second address ACKed, TX entered, busy never drops.
REQ-036 rst asserted during 5th data bit of a read -> sda_oe=0 next clk, state=0, following full write transaction succeeds.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with a 7-bit address, byte-wide receive/transmit handshakes and
// open-drain SDA control. Bus lines are oversampled on clk through 2-flop synchronizers.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       ack_en,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6
  } state_t;

  state_t     cur;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       scl_high;
  logic       start_det;
  logic       stop_det;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic [6:0] tx_shift;
  logic       rw;
  logic       ack_phase;

  // Synchronizers idle high so a bus that is already idle is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;

  // SCL must be high in both samples, so an SDA change coinciding with an SCL edge is ignored.
  assign scl_high  = scl_s & scl_prev;
  assign start_det = scl_high & sda_prev & ~sda_s;
  assign stop_det  = scl_high & ~sda_prev & sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      sda_oe    <= 1'b0;
      tx_load   <= 1'b0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 8'h00;
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      tx_shift  <= 7'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
    end else begin
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;
      if (start_det) begin
        cur       <= ADDR;
        bit_cnt   <= 3'd0;
        sda_oe    <= 1'b0;
        ack_phase <= 1'b0;
      end else if (stop_det) begin
        cur       <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
      end else begin
        case (cur)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[5:0], sda_s};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift_reg == TARGET_ADDR) begin
                  cur       <= ADDR_ACK;
                  busy      <= 1'b1;
                  rw        <= sda_s;
                  ack_phase <= 1'b0;
                end else begin
                  cur <= IDLE;
                end
              end
            end
          end
          // First fall drives the ACK; the second ends it and starts the data phase.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                if (rw) begin
                  tx_load  <= 1'b1;
                  tx_shift <= tx_data[6:0];
                  sda_oe   <= ~tx_data[7];
                  cur      <= TX;
                end else begin
                  sda_oe <= 1'b0;
                  cur    <= RX;
                end
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[5:0], sda_s};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {shift_reg, sda_s};
                rx_valid  <= 1'b1;
                cur       <= RX_ACK;
                ack_phase <= 1'b0;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= ack_en;
                ack_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                cur       <= RX;
              end
            end
          end
          // Bit 7 went out on entry; each fall shifts out the next bit, the eighth releases SDA.
          TX: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                cur       <= TX_ACK;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
              end
            end
          end
          // A master NACK ends the read; busy is kept until the master sends STOP.
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                cur    <= IDLE;
                sda_oe <= 1'b0;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd0;
              tx_load   <= 1'b1;
              tx_shift  <= tx_data[6:0];
              sda_oe    <= ~tx_data[7];
              cur       <= TX;
            end
          end
          default: begin
            cur    <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus master drives table and random transactions,
// and results are compared with expectations derived from the I2C transaction rules.
module tb_i2c_target;

  localparam logic [6:0] ADDR = 7'h52;

  typedef struct {
    logic [7:0]      addr;
    int              nbytes;
    logic [2:0][7:0] data;
    logic            ack_en;
    logic            exp_addr_ack;
    logic            exp_data_ack;
    int              exp_rx;
    int              exp_tx;
    logic [7:0]      exp_last_rx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       ack_en = 1'b1;
  logic       sda_oe;
  logic       tx_load;
  logic       rx_valid;
  logic       busy;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic [2:0] state;
  logic [7:0] tx_bytes [4];
  logic       bus_sample;
  int         tx_base = 0;
  int         tx_total = 0;
  int         rx_total = 0;
  int         busy_low = 0;
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs [10];

  wire sda_bus = sda_m & ~sda_oe;
  assign tx_data = tx_bytes[2'(tx_total - tx_base)];

  i2c_target #(.TARGET_ADDR(ADDR)) dut (
    .clk(clk),
    .rst(rst),
    .scl_in(scl),
    .sda_in(sda_bus),
    .sda_oe(sda_oe),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ack_en(ack_en),
    .busy(busy),
    .state(state)
  );

  always #5 clk = ~clk;

  // Event counters; transactions compare differences of these totals.
  always @(negedge clk) begin
    if (tx_load) tx_total <= tx_total + 1;
    if (rx_valid) rx_total <= rx_total + 1;
    if (!busy) busy_low <= busy_low + 1;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One SCL period of 20 clk; SDA only changes mid-low, the bus is sampled mid-high.
  task automatic clock_bit(input logic b);
    sda_m = b;
    ticks(5);
    scl = 1'b1;
    ticks(5);
    bus_sample = sda_bus;
    ticks(5);
    scl = 1'b0;
    ticks(5);
  endtask

  task automatic send_start();
    sda_m = 1'b1;
    ticks(5);
    scl = 1'b1;
    ticks(5);
    sda_m = 1'b0;
    ticks(5);
    scl = 1'b0;
    ticks(5);
  endtask

  task automatic send_stop();
    sda_m = 1'b0;
    ticks(5);
    scl = 1'b1;
    ticks(5);
    sda_m = 1'b1;
    ticks(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_lvl);
    for (int i = 7; i >= 0; i--) clock_bit(b[i]);
    clock_bit(1'b1);
    ack_lvl = bus_sample;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1);
      b[i] = bus_sample;
    end
    clock_bit(nack);
  endtask

  function automatic vec_t mk(input logic [7:0] addr, input int n, input logic [23:0] data,
                              input logic ae, input logic eaa, input logic eda,
                              input int erx, input int etx, input logic [7:0] elast);
    vec_t v;
    v.addr = addr; v.nbytes = n; v.data = data; v.ack_en = ae;
    v.exp_addr_ack = eaa; v.exp_data_ack = eda;
    v.exp_rx = erx; v.exp_tx = etx; v.exp_last_rx = elast;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v, input int k);
    logic       lvl;
    logic [7:0] rb;
    int         rx0;
    int         tx0;
    rx0 = rx_total;
    tx0 = tx_total;
    tx_base = tx_total;
    ack_en = v.ack_en;
    for (int i = 0; i < 3; i++) tx_bytes[i] = v.data[i];
    send_start();
    write_byte(v.addr, lvl);
    check_output($sformatf("v%0d_addr_ack", k), 32'(lvl), 32'(!v.exp_addr_ack));
    if (v.exp_addr_ack) begin
      check_output($sformatf("v%0d_busy_addr", k), 32'(busy), 32'd1);
      if (!v.addr[0]) begin
        for (int i = 0; i < v.nbytes; i++) begin
          write_byte(v.data[i], lvl);
          check_output($sformatf("v%0d_data_ack%0d", k, i), 32'(lvl), 32'(!v.exp_data_ack));
        end
      end else begin
        for (int i = 0; i < v.nbytes; i++) begin
          read_byte(i == v.nbytes - 1, rb);
          check_output($sformatf("v%0d_read%0d", k, i), 32'(rb), 32'(v.data[i]));
        end
        check_output($sformatf("v%0d_nack_oe", k), 32'(sda_oe), 32'd0);
        check_output($sformatf("v%0d_nack_state", k), 32'(state), 32'd0);
        check_output($sformatf("v%0d_nack_busy", k), 32'(busy), 32'd1);
      end
    end else begin
      check_output($sformatf("v%0d_miss_state", k), 32'(state), 32'd0);
    end
    send_stop();
    check_output($sformatf("v%0d_rx_pulses", k), 32'(rx_total - rx0), 32'(v.exp_rx));
    check_output($sformatf("v%0d_tx_loads", k), 32'(tx_total - tx0), 32'(v.exp_tx));
    check_output($sformatf("v%0d_rx_data", k), 32'(rx_data), 32'(v.exp_last_rx));
    check_output($sformatf("v%0d_busy_stop", k), 32'(busy), 32'd0);
    check_output($sformatf("v%0d_state_stop", k), 32'(state), 32'd0);
    ticks(10);
  endtask

  initial begin
    logic       lvl;
    logic [7:0] rb;
    logic [7:0] model_rx;
    logic       wr;
    logic       rd;
    int         snap;
    int         snap_tx;

    for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h00;

    // Directed vectors, then random ones whose expectations come from the transaction rules.
    vecs[0] = mk(8'hA4, 1, 24'h00003C, 1'b1, 1'b1, 1'b1, 1, 0, 8'h3C);
    vecs[1] = mk(8'hA6, 1, 24'h000000, 1'b1, 1'b0, 1'b1, 0, 0, 8'h3C);
    vecs[2] = mk(8'hA5, 2, 24'h000F96, 1'b1, 1'b1, 1'b1, 0, 2, 8'h3C);
    vecs[3] = mk(8'hA4, 1, 24'h000081, 1'b0, 1'b1, 1'b0, 1, 0, 8'h81);
    model_rx = 8'h81;
    for (int k = 4; k < 10; k++) begin
      vec_t v;
      v.addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {ADDR, 1'($urandom)};
      v.nbytes = $urandom_range(1, 3);
      v.data = 24'($urandom);
      v.ack_en = 1'($urandom);
      v.exp_addr_ack = (v.addr[7:1] == ADDR);
      v.exp_data_ack = v.ack_en;
      wr = v.exp_addr_ack && !v.addr[0];
      rd = v.exp_addr_ack && v.addr[0];
      v.exp_rx = wr ? v.nbytes : 0;
      v.exp_tx = rd ? v.nbytes : 0;
      if (wr) model_rx = v.data[v.nbytes - 1];
      v.exp_last_rx = model_rx;
      vecs[k] = v;
    end

    ticks(3);
    check_output("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_rx_data", 32'(rx_data), 32'd0);
    check_output("rst_tx_load", 32'(tx_load), 32'd0);
    check_output("rst_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    ticks(5);

    for (int k = 0; k < 10; k++) apply_stimulus(vecs[k], k);

    // Write one byte, repeated START, then a read: busy must hold throughout.
    ack_en = 1'b1;
    tx_base = tx_total;
    tx_bytes[0] = 8'hC5;
    send_start();
    write_byte(8'hA4, lvl);
    check_output("rs_addr_w_ack", 32'(lvl), 32'd0);
    write_byte(8'h5A, lvl);
    check_output("rs_data_ack", 32'(lvl), 32'd0);
    snap = busy_low;
    snap_tx = tx_total;
    send_start();
    write_byte(8'hA5, lvl);
    check_output("rs_addr_r_ack", 32'(lvl), 32'd0);
    check_output("rs_state_tx", 32'(state), 32'd5);
    check_output("rs_tx_load", 32'(tx_total - snap_tx), 32'd1);
    read_byte(1'b1, rb);
    check_output("rs_read", 32'(rb), 32'hC5);
    check_output("rs_busy_held", 32'(busy_low - snap), 32'd0);
    send_stop();
    check_output("rs_rx_data", 32'(rx_data), 32'h5A);
    check_output("rs_busy_stop", 32'(busy), 32'd0);
    ticks(10);

    // Reset in the middle of a read while the target is pulling SDA low.
    tx_base = tx_total;
    tx_bytes[0] = 8'h00;
    send_start();
    write_byte(8'hA5, lvl);
    check_output("mr_addr_ack", 32'(lvl), 32'd0);
    for (int i = 0; i < 4; i++) clock_bit(1'b1);
    check_output("mr_pre_oe", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    ticks(1);
    check_output("mr_rst_oe", 32'(sda_oe), 32'd0);
    check_output("mr_rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    send_stop();
    ticks(10);
    check_output("mr_rx_cleared", 32'(rx_data), 32'd0);
    snap = rx_total;
    send_start();
    write_byte(8'hA4, lvl);
    check_output("mr_w_addr_ack", 32'(lvl), 32'd0);
    write_byte(8'hC3, lvl);
    check_output("mr_w_data_ack", 32'(lvl), 32'd0);
    send_stop();
    check_output("mr_w_rx_data", 32'(rx_data), 32'hC3);
    check_output("mr_w_rx_pulse", 32'(rx_total - snap), 32'd1);
    check_output("mr_w_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
